frame_feed_ctrl: RTL and testbench

Frame-level flow controller between the upstream pixel source and the 4-line-buffer 3×3 window generator. It admits one frame of IMG_H rows × LINE_W pixels using a line-credit scheme, so that no line buffer is overwritten before it has been read. It returns a credit on each end-of-read-line interrupt from the window generator. It reports frame completion once all IMG_H−2 window rows have been read out.

---
 rtl/frame_feed_ctrl.sv | 149 ++++++++++++++
 tb/tb_frame_feed_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_feed_ctrl.sv
// frame_feed_ctrl
//   Frame-level flow controller between an upstream pixel source and a
//   NUM_LB-line-buffer 3x3 window generator. Admits IMG_H lines of LINE_W
//   pixels against a line-credit pool so no line buffer is overwritten before
//   it has been read. A credit comes back on every end-of-read-line interrupt.
//   Frame completion is reported once IMG_H-2 window rows have been read.
//
// Ports
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_start                 frame start pulse, honoured only in IDLE
//   i_abort                 synchronous abort back to IDLE from any state
//   i_s_data/i_s_valid      upstream pixel stream
//   o_s_ready               upstream ready
//   o_pix_data/o_pix_valid  pixel stream to the window generator
//   i_intr                  one-row-read pulse from the window generator
//   o_busy                  not IDLE
//   o_frame_done            one-cycle frame completion pulse
//   o_lines_sent            lines fully transferred this frame
//   o_err                   sticky credit-protocol error
module frame_feed_ctrl #(
  parameter int LINE_W = 512,
  parameter int IMG_H  = 512,
  parameter int NUM_LB = 4,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [DATA_W-1:0] i_s_data,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  output logic [DATA_W-1:0] o_pix_data,
  output logic              o_pix_valid,
  input  logic              i_intr,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic [9:0]        o_lines_sent,
  output logic              o_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEND  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int CW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam logic [CW-1:0] COL_LAST   = CW'(LINE_W - 1);
  localparam logic [2:0]    CRED_MAX   = 3'(NUM_LB);
  localparam logic [9:0]    LINES_LAST = 10'(IMG_H);
  localparam logic [9:0]    ROWS_LAST  = 10'(IMG_H - 2);

  logic [2:0]    state_q,     state_d;
  logic [2:0]    credits_q,   credits_d;
  logic [CW-1:0] col_q,       col_d;
  logic [9:0]    lines_q,     lines_d;
  logic [9:0]    rows_read_q, rows_read_d;
  logic          err_q,       err_d;

  logic xfer, line_end;

  assign o_s_ready    = (state_q == S_SEND);
  assign o_pix_data   = i_s_data;
  assign o_pix_valid  = i_s_valid & o_s_ready;
  assign o_busy       = (state_q != S_IDLE);
  assign o_frame_done = (state_q == S_DONE);
  assign o_lines_sent = lines_q;
  assign o_err        = err_q;

  assign xfer     = i_s_valid & o_s_ready;
  assign line_end = xfer & (col_q == COL_LAST);

  always_comb begin
    state_d     = state_q;
    credits_d   = credits_q;
    col_d       = col_q;
    lines_d     = lines_q;
    rows_read_d = rows_read_q;
    err_d       = err_q;

    if (i_abort) begin
      // lines_sent and err are left alone so software can see where it stopped
      state_d     = S_IDLE;
      credits_d   = 3'd0;
      col_d       = '0;
      rows_read_d = 10'd0;
    end else if (state_q == S_IDLE) begin
      if (i_intr) err_d = 1'b1;
      if (i_start) begin
        state_d     = S_SEND;
        credits_d   = CRED_MAX;
        col_d       = '0;
        lines_d     = 10'd0;
        rows_read_d = 10'd0;
        err_d       = 1'b0;
      end
    end else begin
      // Credit pool: a line end consumes one, an interrupt returns one; both
      // in the same cycle cancel. Returning into a full pool is an error.
      if (i_intr) begin
        rows_read_d = rows_read_q + 10'd1;
        if (credits_q == CRED_MAX) err_d = 1'b1;
      end
      if (line_end && !i_intr)
        credits_d = credits_q - 3'd1;
      else if (i_intr && !line_end && credits_q != CRED_MAX)
        credits_d = credits_q + 3'd1;

      if (xfer) begin
        col_d = line_end ? '0 : col_q + CW'(1);
        if (line_end) lines_d = lines_q + 10'd1;
      end

      case (state_q)
        S_SEND: begin
          if (line_end) begin
            if (lines_d == LINES_LAST)  state_d = S_DRAIN;
            else if (credits_d == 3'd0) state_d = S_WAIT;
          end
        end
        // registered credit check: an interrupt re-opens ready two cycles later
        S_WAIT:  if (credits_q != 3'd0) state_d = S_SEND;
        S_DRAIN: if (rows_read_q == ROWS_LAST) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      credits_q   <= 3'd0;
      col_q       <= '0;
      lines_q     <= 10'd0;
      rows_read_q <= 10'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      credits_q   <= credits_d;
      col_q       <= col_d;
      lines_q     <= lines_d;
      rows_read_q <= rows_read_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_frame_feed_ctrl.sv
module tb_frame_feed_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // default-parameter instance
  logic       d_start = 0, d_abort = 0, d_valid = 0, d_intr = 0;
  logic [7:0] d_data = 0;
  logic       d_ready, d_pix_valid, d_busy, d_done, d_err;
  logic [7:0] d_pix_data;
  logic [9:0] d_lines;
  logic       d_xfer;

  frame_feed_ctrl u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(d_start), .i_abort(d_abort),
    .i_s_data(d_data), .i_s_valid(d_valid), .o_s_ready(d_ready),
    .o_pix_data(d_pix_data), .o_pix_valid(d_pix_valid), .i_intr(d_intr),
    .o_busy(d_busy), .o_frame_done(d_done), .o_lines_sent(d_lines), .o_err(d_err)
  );

  // small instance: LINE_W=2, IMG_H=5, NUM_LB=3
  logic       s_start = 0, s_abort = 0, s_valid = 0, s_intr = 0;
  logic [7:0] s_data = 0;
  logic       s_ready, s_pix_valid, s_busy, s_done, s_err;
  logic [7:0] s_pix_data;
  logic [9:0] s_lines;

  frame_feed_ctrl #(.LINE_W(2), .IMG_H(5), .NUM_LB(3), .DATA_W(8)) u_sml (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(s_start), .i_abort(s_abort),
    .i_s_data(s_data), .i_s_valid(s_valid), .o_s_ready(s_ready),
    .o_pix_data(s_pix_data), .o_pix_valid(s_pix_valid), .i_intr(s_intr),
    .o_busy(s_busy), .o_frame_done(s_done), .o_lines_sent(s_lines), .o_err(s_err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic d_step(input logic st, input logic ab, input logic v, input logic it);
    @(negedge clk);
    d_start = st; d_abort = ab; d_valid = v; d_intr = it;
    #1 d_xfer = d_pix_valid;
    @(posedge clk);
    #1;
  endtask

  // run with valid high until ready drops; returns transfers seen
  task automatic d_run(input int intr_at, output int cnt);
    cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      d_step(0, 0, 1, cnt == intr_at);
      if (d_xfer) cnt++;
      if (!d_ready) break;
    end
  endtask

  typedef struct packed {
    logic st, ab, v, it;
    logic rdy, busy, done, pv, err;
    logic [9:0] lines;
  } vec_t;

  function automatic vec_t mk(input logic st, ab, v, it, rdy, busy, done, pv, err,
                              input int lines);
    vec_t r;
    r.st = st; r.ab = ab; r.v = v; r.it = it;
    r.rdy = rdy; r.busy = busy; r.done = done; r.pv = pv; r.err = err;
    r.lines = 10'(lines);
    return r;
  endfunction

  vec_t tbl [0:15];

  initial begin
    int cnt, given, xfers, dones, last_it, done_c, low_c;
    logic prev_it, finished;

    //           st ab v  it  rdy busy done pv err lines
    tbl[0]  = mk(0, 0, 0, 0,  0,  0,   0,   0, 0,  0); // idle
    tbl[1]  = mk(0, 0, 0, 1,  0,  0,   0,   0, 1,  0); // intr in IDLE -> err
    tbl[2]  = mk(1, 0, 0, 0,  1,  1,   0,   0, 0,  0); // start clears err
    tbl[3]  = mk(0, 0, 1, 0,  1,  1,   0,   1, 0,  0);
    tbl[4]  = mk(0, 0, 1, 0,  1,  1,   0,   1, 0,  1); // line 1 end
    tbl[5]  = mk(0, 0, 0, 0,  1,  1,   0,   0, 0,  1); // bubble
    tbl[6]  = mk(0, 0, 1, 0,  1,  1,   0,   1, 0,  1);
    tbl[7]  = mk(1, 0, 1, 0,  1,  1,   0,   1, 0,  2); // start ignored
    tbl[8]  = mk(0, 0, 1, 0,  1,  1,   0,   1, 0,  2);
    tbl[9]  = mk(0, 0, 1, 0,  0,  1,   0,   0, 0,  3); // credits out -> WAIT
    tbl[10] = mk(0, 0, 1, 1,  0,  1,   0,   0, 0,  3); // credit returns
    tbl[11] = mk(0, 0, 1, 0,  1,  1,   0,   1, 0,  3); // back to SEND
    tbl[12] = mk(0, 1, 1, 0,  0,  0,   0,   0, 0,  3); // abort, lines held
    tbl[13] = mk(0, 0, 0, 1,  0,  0,   0,   0, 1,  3);
    tbl[14] = mk(0, 1, 0, 0,  0,  0,   0,   0, 1,  3); // err held over abort
    tbl[15] = mk(1, 0, 0, 0,  1,  1,   0,   0, 0,  0);

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {d_ready, d_pix_valid, d_busy, d_done, d_err, d_lines}, 0);
    @(negedge clk) rst_n = 1'b1;

    // ---- table-driven vectors on the small instance
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      s_start = tbl[i].st; s_abort = tbl[i].ab; s_valid = tbl[i].v; s_intr = tbl[i].it;
      @(posedge clk);
      #1;
      n_checks++;
      if ({s_ready, s_busy, s_done, s_pix_valid, s_err, s_lines} !==
          {tbl[i].rdy, tbl[i].busy, tbl[i].done, tbl[i].pv, tbl[i].err, tbl[i].lines}) begin
        n_errors++;
        $display("FAIL vec%0d: rdy/busy/done/pv/err=%b%b%b%b%b lines=%0d expected %b%b%b%b%b lines=%0d",
                 i, s_ready, s_busy, s_done, s_pix_valid, s_err, s_lines,
                 tbl[i].rdy, tbl[i].busy, tbl[i].done, tbl[i].pv, tbl[i].err, tbl[i].lines);
      end
    end
    @(negedge clk);
    s_start = 0; s_abort = 0; s_valid = 0; s_intr = 0;

    // ---- async reset mid-SEND at col 100
    d_step(1, 0, 0, 0);
    for (int i = 0; i < 100; i++) d_step(0, 0, 1, 0);
    d_data = 8'hA5;
    #1 check("pix_data_pass", d_pix_data, 8'hA5);
    check("col_before_rst", u_dut.col_q, 100);
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", {d_ready, d_pix_valid, d_busy, d_done, d_err, d_lines}, 0);
    check("async_rst_col", u_dut.col_q, 0);
    @(negedge clk) rst_n = 1'b1;

    // ---- clean frame, no interrupts: NUM_LB lines then WAIT
    d_step(1, 0, 0, 0);
    check("start_ready", d_ready, 1);
    d_run(-1, cnt);
    check("burst_xfers", cnt, 2048);
    check("burst_lines", d_lines, 4);
    check("burst_state_wait", u_dut.state_q, 2);
    check("burst_credits", u_dut.credits_q, 0);

    // ---- one interrupt from WAIT: ready two cycles later, one more line
    d_step(0, 0, 1, 1);
    check("intr_ready_t1", d_ready, 0);
    check("intr_credits_t1", u_dut.credits_q, 1);
    d_step(0, 0, 1, 0);
    check("intr_ready_t2", d_ready, 1);
    d_run(-1, cnt);
    check("one_line_xfers", cnt, 512);
    check("one_line_lines", d_lines, 5);
    check("one_line_state_wait", u_dut.state_q, 2);

    // ---- intr into a full pool, then abort mid-line
    d_step(0, 1, 0, 0);
    d_step(1, 0, 0, 0);
    d_step(0, 0, 0, 1);
    check("sat_err", d_err, 1);
    check("sat_credits", u_dut.credits_q, 4);
    for (int i = 0; i < 600; i++) d_step(0, 0, 1, 0);
    d_step(0, 1, 1, 0);
    check("abort_idle", {d_busy, d_ready, d_pix_valid}, 0);
    check("abort_lines_held", d_lines, 1);
    check("abort_err_held", d_err, 1);
    check("abort_col_clear", u_dut.col_q, 0);

    // ---- intr coincident with last pixel of line 2 (index 1535)
    d_step(1, 0, 0, 0);
    check("restart_err_clear", d_err, 0);
    d_run(1535, cnt);
    check("coincident_xfers", cnt, 2560);
    check("coincident_lines", d_lines, 5);
    check("coincident_err", d_err, 0);

    // ---- full small frame, 50% valid, window-generator interrupt model
    @(negedge clk); s_abort = 1;
    @(negedge clk); s_abort = 0; s_start = 1;
    @(negedge clk); s_start = 0;
    given = 0; xfers = 0; dones = 0; last_it = -1; done_c = -1; low_c = -1;
    prev_it = 0; finished = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      s_valid = c[0];
      s_intr = !prev_it && (given < 3) && (int'(s_lines) > given + 2);
      if (s_intr) begin given++; last_it = c; end
      prev_it = s_intr;
      #1;
      if (s_pix_valid) xfers++;
      if (s_done) begin dones++; done_c = c; end
      if (dones > 0 && !s_busy) begin low_c = c; finished = 1; break; end
    end
    s_valid = 0; s_intr = 0;
    check("frame_finished", finished, 1);
    check("frame_xfers", xfers, 10);
    check("frame_intrs", given, 3);
    check("frame_rows_read", u_sml.rows_read_q, 3);
    check("frame_done_pulses", dones, 1);
    check("frame_err", s_err, 0);
    check("frame_done_latency", done_c - last_it, 2);
    check("frame_busy_low", low_c - last_it, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
